// File: rtl/dut_sampler_pkg.sv
// Shared types and constants for the dut_sampler stimulus/capture sequencer.
// The optional result parity (macro DUT_SAMPLER_PARITY_EN) is handled in dut_sampler.sv.
package dut_sampler_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam int DUT_BUS_WIDTH = 32;
   localparam int SEL_W         = $clog2(DUT_BUS_WIDTH);
   localparam int SETTLE_CNT_W  = 8;

endpackage : dut_sampler_pkg

// File: rtl/dut_sampler_settle_timer.sv
// Loadable down-counter that paces each captured bit; zero_o flags the capture cycle.
module dut_sampler_settle_timer
   import dut_sampler_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load_i,
   input  logic [SETTLE_CNT_W-1:0] load_val_i,
   input  logic                    en_i,
   output logic                    zero_o
);

   logic [SETTLE_CNT_W-1:0] count_q;
   logic [SETTLE_CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule : dut_sampler_settle_timer

// File: rtl/dut_sampler.sv
// Stimulus/capture sequencer: applies a command word to the DUT, sweeps the output
// select bit by bit and returns the captured word. Optional rsp_parity via DUT_SAMPLER_PARITY_EN.
module dut_sampler
   import dut_sampler_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 2
)
(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [DUT_BUS_WIDTH-1:0] cmd_data,
   input  logic                     sweep_abort,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DUT_BUS_WIDTH-1:0] rsp_data,
`ifdef DUT_SAMPLER_PARITY_EN
   output logic                     rsp_parity,
`endif
   output logic                     busy,
   output logic [DUT_BUS_WIDTH-1:0] dut_input,
   output logic [DUT_BUS_WIDTH-1:0] dut_signal_select,
   input  logic                     dut_output
);

   localparam logic [SEL_W-1:0]        LAST_SEL   = SEL_W'(WIDTH - 1);
   localparam logic [SETTLE_CNT_W-1:0] SETTLE_VAL = SETTLE_CNT_W'(SETTLE_CYCLES);

   state_e                   state_q, state_d;
   logic [SEL_W-1:0]         sel_q, sel_d;
   logic [DUT_BUS_WIDTH-1:0] result_q, result_d;
   logic [DUT_BUS_WIDTH-1:0] dut_input_q, dut_input_d;
   logic [DUT_BUS_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                     rsp_valid_q, rsp_valid_d;
`ifdef DUT_SAMPLER_PARITY_EN
   logic                     parity_q, parity_d;
`endif

   logic timer_load;
   logic timer_en;
   logic timer_zero;

   dut_sampler_settle_timer u_settle_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load_i     (timer_load),
      .load_val_i (SETTLE_VAL),
      .en_i       (timer_en),
      .zero_o     (timer_zero)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      result_d    = result_q;
      dut_input_d = dut_input_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = rsp_valid_q;
`ifdef DUT_SAMPLER_PARITY_EN
      parity_d    = parity_q;
`endif
      timer_load  = 1'b0;
      timer_en    = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               dut_input_d = cmd_data;
               sel_d       = '0;
               result_d    = '0;
               timer_load  = 1'b1;
               state_d     = SETTLE;
            end
         end
         SETTLE: begin
            // Abort wins over a capture landing in the same cycle.
            if (sweep_abort) begin
               sel_d   = '0;
               state_d = IDLE;
            end else if (!timer_zero) begin
               timer_en = 1'b1;
            end else begin
               result_d[sel_q] = dut_output;
               if (sel_q == LAST_SEL) begin
                  state_d = DONE;
               end else begin
                  sel_d      = sel_q + 1'b1;
                  timer_load = 1'b1;
               end
            end
         end
         DONE: begin
            // First DONE cycle publishes the finished word; rsp_data then holds until taken.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = result_q;
`ifdef DUT_SAMPLER_PARITY_EN
               parity_d    = ^result_q;
`endif
            end else if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               sel_d       = '0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         result_q    <= '0;
         dut_input_q <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
`ifdef DUT_SAMPLER_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         result_q    <= result_d;
         dut_input_q <= dut_input_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
`ifdef DUT_SAMPLER_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   assign cmd_ready         = (state_q == IDLE);
   assign busy              = (state_q == SETTLE);
   assign rsp_valid         = rsp_valid_q;
   assign rsp_data          = rsp_data_q;
   assign dut_input         = dut_input_q;
   assign dut_signal_select = {{(DUT_BUS_WIDTH - SEL_W){1'b0}}, sel_q};
`ifdef DUT_SAMPLER_PARITY_EN
   assign rsp_parity        = parity_q;
`endif

endmodule : dut_sampler

// File: tb/tb_dut_sampler.sv
// Bench for dut_sampler against a reference adder DUT (selected bit of upper half + lower half).
module tb_dut_sampler;

   typedef struct {
      logic [31:0] cmd;
      logic [31:0] exp;
   } vec_t;

   logic        clk;
   logic        rst_n;
   int          n_checks;
   int          n_fail;

   // Instance A: default parameters
   logic        cmd_valid, cmd_ready, sweep_abort, rsp_valid, rsp_ready, busy, dut_output;
   logic [31:0] cmd_data, rsp_data, dut_input, dut_sel;
`ifdef DUT_SAMPLER_PARITY_EN
   logic        rsp_parity;
`endif

   // Instance B: WIDTH = 8, SETTLE_CYCLES = 0
   logic        b_cmd_valid, b_cmd_ready, b_sweep_abort, b_rsp_valid, b_rsp_ready, b_busy, b_dut_output;
   logic [31:0] b_cmd_data, b_rsp_data, b_dut_input, b_dut_sel;
`ifdef DUT_SAMPLER_PARITY_EN
   logic        b_rsp_parity;
`endif

   function automatic logic model_bit(input logic [31:0] din, input logic [31:0] sel);
      logic [31:0] s;
      s = {16'h0, din[31:16]} + {16'h0, din[15:0]};
      if (sel < 32) return s[sel[4:0]];
      return 1'b0;
   endfunction

   assign dut_output   = model_bit(dut_input, dut_sel);
   assign b_dut_output = model_bit(b_dut_input, b_dut_sel);

   dut_sampler u_dut_a (
      .clk               (clk),
      .reset_n           (rst_n),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_data          (cmd_data),
      .sweep_abort       (sweep_abort),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_data          (rsp_data),
`ifdef DUT_SAMPLER_PARITY_EN
      .rsp_parity        (rsp_parity),
`endif
      .busy              (busy),
      .dut_input         (dut_input),
      .dut_signal_select (dut_sel),
      .dut_output        (dut_output)
   );

   dut_sampler #(.WIDTH(8), .SETTLE_CYCLES(0)) u_dut_b (
      .clk               (clk),
      .reset_n           (rst_n),
      .cmd_valid         (b_cmd_valid),
      .cmd_ready         (b_cmd_ready),
      .cmd_data          (b_cmd_data),
      .sweep_abort       (b_sweep_abort),
      .rsp_valid         (b_rsp_valid),
      .rsp_ready         (b_rsp_ready),
      .rsp_data          (b_rsp_data),
`ifdef DUT_SAMPLER_PARITY_EN
      .rsp_parity        (b_rsp_parity),
`endif
      .busy              (b_busy),
      .dut_input         (b_dut_input),
      .dut_signal_select (b_dut_sel),
      .dut_output        (b_dut_output)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called #1 after a rising edge with the block idle; returns #1 after the accepting edge.
   task automatic send_cmd(input logic [31:0] c);
      chk("cmd_ready before send", {31'h0, cmd_ready}, 32'h1);
      cmd_data  = c;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output logic [31:0] d, output int lat);
      lat = 0;
      while (lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
         if (rsp_valid) break;
      end
      d = rsp_data;
   endtask

   task automatic handshake();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("rsp_valid after handshake", {31'h0, rsp_valid}, 32'h0);
   endtask

   task automatic wait_sel(input logic [31:0] k);
      int n;
      n = 0;
      while (dut_sel != k && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("reach select index", dut_sel, k);
   endtask

   vec_t        vecs[5];
   logic [31:0] d;
   int          lat;
   bit          stable, seen;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      vecs[0] = '{32'h0001_0002, 32'h0000_0003};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0001_FFFE};
      vecs[2] = '{32'h0000_0000, 32'h0000_0000};
      vecs[3] = '{32'h1234_5678, 32'h0000_68AC};
      vecs[4] = '{32'h8000_8000, 32'h0001_0000};

      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_data = '0; sweep_abort = 1'b0; rsp_ready = 1'b0;
      b_cmd_valid = 1'b0; b_cmd_data = '0; b_sweep_abort = 1'b0; b_rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("reset busy", {31'h0, busy}, 32'h0);
      chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("reset rsp_data", rsp_data, 32'h0);
      chk("reset dut_input", dut_input, 32'h0);
      chk("reset select", dut_sel, 32'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven sweeps with the default configuration
      for (int i = 0; i < 5; i++) begin
         send_cmd(vecs[i].cmd);
         chk("busy after accept", {31'h0, busy}, 32'h1);
         chk("dut_input latched", dut_input, vecs[i].cmd);
         wait_rsp(d, lat);
         chk("vector rsp_data", d, vecs[i].exp);
         chk("vector latency", 32'(lat), 32'd97);
`ifdef DUT_SAMPLER_PARITY_EN
         chk("vector rsp_parity", {31'h0, rsp_parity}, {31'h0, ^vecs[i].exp});
`endif
         handshake();
      end

      // Back-pressure in DONE with a competing command
      send_cmd(32'h0001_0002);
      wait_rsp(d, lat);
      chk("hold rsp_data", d, 32'h3);
      cmd_data  = 32'h0002_0003;
      cmd_valid = 1'b1;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         if (!rsp_valid || rsp_data !== 32'h3 || cmd_ready) stable = 1'b0;
      end
      chk("hold stable, cmd blocked", {31'h0, stable}, 32'h1);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("bubble cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("bubble busy", {31'h0, busy}, 32'h0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      chk("accept after bubble", {31'h0, busy}, 32'h1);
      chk("second dut_input", dut_input, 32'h0002_0003);
      wait_rsp(d, lat);
      chk("second rsp_data", d, 32'h5);
      chk("second latency", 32'(lat), 32'd97);
      handshake();

      // Abort at select 5
      send_cmd(32'hFFFF_FFFF);
      wait_sel(32'd5);
      sweep_abort = 1'b1;
      @(posedge clk);
      #1;
      sweep_abort = 1'b0;
      chk("abort busy", {31'h0, busy}, 32'h0);
      chk("abort cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("abort select", dut_sel, 32'h0);
      chk("abort dut_input kept", dut_input, 32'hFFFF_FFFF);
      seen = 1'b0;
      for (int k = 0; k < 120; k++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) seen = 1'b1;
      end
      chk("abort no response", {31'h0, seen}, 32'h0);
      send_cmd(32'h0002_0003);
      wait_rsp(d, lat);
      chk("post-abort rsp_data", d, 32'h5);
      handshake();

      // Asynchronous reset at select 17
      send_cmd(32'h1234_5678);
      wait_sel(32'd17);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid reset cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("mid reset busy", {31'h0, busy}, 32'h0);
      chk("mid reset rsp_data", rsp_data, 32'h0);
      chk("mid reset dut_input", dut_input, 32'h0);
      chk("mid reset select", dut_sel, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after release cmd_ready", {31'h0, cmd_ready}, 32'h1);
      chk("after release rsp_valid", {31'h0, rsp_valid}, 32'h0);

      // WIDTH = 8, SETTLE_CYCLES = 0
      chk("B cmd_ready", {31'h0, b_cmd_ready}, 32'h1);
      b_cmd_data  = 32'h0000_0081;
      b_cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      b_cmd_valid = 1'b0;
      stable = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (b_dut_sel !== 32'(k)) stable = 1'b0;
         if (k < 7) begin
            @(posedge clk);
            #1;
         end
      end
      chk("B select walks 0..7", {31'h0, stable}, 32'h1);
      lat = 7;
      while (lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
         if (b_rsp_valid) break;
      end
      chk("B latency", 32'(lat), 32'd9);
      chk("B rsp_data", b_rsp_data, 32'h0000_0081);
      chk("B select held in DONE", b_dut_sel, 32'd7);
      b_rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      b_rsp_ready = 1'b0;
      chk("B back to idle", {31'h0, b_cmd_ready}, 32'h1);
      chk("B select cleared", b_dut_sel, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dut_sampler
